// File: rtl/elbeth_lsu_if.sv
// Bundled core-request, response and memory-port signals of the elbeth load/store unit.
// The LSU sits on the slave modport; the core/memory environment uses master.
interface elbeth_lsu_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_data;

  logic                  resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_misaligned;
  logic                  resp_timeout;

  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data_out;
  logic [3:0]            mem_wr;
  logic [31:0]           mem_data_in;
  logic                  mem_ready;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_data,
    input  req_ready,
    input  resp_valid, resp_data, resp_misaligned, resp_timeout,
    input  mem_enable, mem_addr, mem_data_out, mem_wr,
    output mem_data_in, mem_ready
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_data,
    output req_ready,
    output resp_valid, resp_data, resp_misaligned, resp_timeout,
    output mem_enable, mem_addr, mem_data_out, mem_wr,
    input  mem_data_in, mem_ready
  );
endinterface

// File: rtl/elbeth_lsu.sv
// Load/store initiator for one elbeth_memory port: byte/half/word accesses with
// lane steering, load extension, misalignment detection and a ready timeout.
module elbeth_lsu #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input logic       clk,
  input logic       rst,
  elbeth_lsu_if.slave bus
);

  // Wide enough to hold TIMEOUT itself; at least one bit when TIMEOUT is 0.
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [1:0]       lane, lane_d, size, size_d;
  logic             uns, uns_d, we, we_d;
  logic             misaligned, timed_out;

  logic                  req_ready_d, mem_enable_d;
  logic                  resp_valid_d, resp_misaligned_d, resp_timeout_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_data_out_d, resp_data_d;
  logic [3:0]            mem_wr_d;

  function automatic logic [3:0] lane_strobes(input logic wr, input logic [1:0] sz,
                                              input logic [1:0] ln);
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << ln;
      2'd1:    s = 4'b0011 << ln;
      default: s = 4'b1111;
    endcase
    return wr ? s : 4'b0000;
  endfunction

  // Store data goes out on every lane so the strobes alone pick the target bytes.
  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] ln, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = w[{ln[1], 4'b0000} +: 16];
    case (sz)
      2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign misaligned = (bus.req_size == 2'd3) ||
                      (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                      (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);

  assign cnt_inc   = cnt + 1'b1;
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // NOTE: the register process uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      lane                <= '0;
      size                <= '0;
      uns                 <= 1'b0;
      we                  <= 1'b0;
      bus.req_ready       <= 1'b1;
      bus.mem_enable      <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_data_out    <= '0;
      bus.mem_wr          <= '0;
      bus.resp_valid      <= 1'b0;
      bus.resp_data       <= '0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_timeout    <= 1'b0;
    end else begin
      state               <= state_d;
      cnt                 <= cnt_d;
      lane                <= lane_d;
      size                <= size_d;
      uns                 <= uns_d;
      we                  <= we_d;
      bus.req_ready       <= req_ready_d;
      bus.mem_enable      <= mem_enable_d;
      bus.mem_addr        <= mem_addr_d;
      bus.mem_data_out    <= mem_data_out_d;
      bus.mem_wr          <= mem_wr_d;
      bus.resp_valid      <= resp_valid_d;
      bus.resp_data       <= resp_data_d;
      bus.resp_misaligned <= resp_misaligned_d;
      bus.resp_timeout    <= resp_timeout_d;
    end
  end

  // NOTE: each combinational process assigns a default to every output first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.req_valid) state_d = misaligned ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ready || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d       = (state_d == IDLE);
    mem_enable_d      = (state_d == ACCESS);
    mem_addr_d        = bus.mem_addr;
    mem_data_out_d    = bus.mem_data_out;
    mem_wr_d          = bus.mem_wr;
    resp_valid_d      = 1'b0;
    resp_data_d       = '0;
    resp_misaligned_d = 1'b0;
    resp_timeout_d    = 1'b0;
    cnt_d             = '0;
    lane_d            = lane;
    size_d            = size;
    uns_d             = uns;
    we_d              = we;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          lane_d = bus.req_addr[1:0];
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          we_d   = bus.req_we;
          if (misaligned) begin
            resp_valid_d      = 1'b1;
            resp_misaligned_d = 1'b1;
          end else begin
            mem_addr_d     = bus.req_addr[ADDR_WIDTH+1:2];
            mem_wr_d       = lane_strobes(bus.req_we, bus.req_size, bus.req_addr[1:0]);
            mem_data_out_d = replicate(bus.req_size, bus.req_data);
          end
        end
      end
      ACCESS: begin
        // A ready on the timeout edge still wins.
        if (bus.mem_ready) begin
          resp_valid_d = 1'b1;
          resp_data_d  = we ? 32'h0 : extract(bus.mem_data_in, size, lane, uns);
          mem_wr_d     = 4'b0000;
        end else if (timed_out) begin
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          mem_wr_d       = 4'b0000;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_elbeth_lsu.sv
// Randomized self-checking bench for elbeth_lsu against a transaction-level model
// of lane steering, load extension, misalignment and timeout behaviour.
module tb_elbeth_lsu;

  localparam int AW      = 8;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 999;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  elbeth_lsu_if #(.ADDR_WIDTH(AW)) bus ();

  elbeth_lsu #(.ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: expected load value from the raw memory word.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input int lane, input logic u);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (lane / 2))) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Called at a negedge with the LSU idle; returns at a negedge with it idle again.
  task automatic run_txn(input logic [AW+1:0] addr, input logic wr, input logic [1:0] sz,
                         input logic u, input logic [31:0] data, input int delay,
                         input logic [31:0] rd_word);
    int          lane;
    int          k;
    bit          mis, done, tmo;
    logic [31:0] exp_wr, exp_dout, exp_rd;

    lane = int'(addr[1:0]);
    mis  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && lane != 0);
    exp_wr   = !wr ? 32'h0 : (sz == 2'd0) ? (32'h1 << lane) :
               (sz == 2'd1) ? (32'h3 << lane) : 32'hF;
    exp_dout = (sz == 2'd0) ? (data & 32'hFF) * 32'h01010101 :
               (sz == 2'd1) ? (data & 32'hFFFF) * 32'h00010001 : data;
    exp_rd   = model_load(rd_word, sz, lane, u);

    check("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid    = 1'b1;
    bus.req_addr     = addr;
    bus.req_we       = wr;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_data     = data;
    @(posedge clk);
    @(negedge clk);
    // Junk requests while busy must be ignored.
    bus.req_valid    = 1'($urandom_range(0, 1));
    bus.req_addr     = (AW + 2)'($urandom);
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_data     = $urandom;

    if (mis) begin
      check("mis_valid", {31'h0, bus.resp_valid}, 32'h1);
      check("mis_flag", {31'h0, bus.resp_misaligned}, 32'h1);
      check("mis_tmo", {31'h0, bus.resp_timeout}, 32'h0);
      check("mis_data", bus.resp_data, 32'h0);
      check("mis_enable", {31'h0, bus.mem_enable}, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("mis_valid_drop", {31'h0, bus.resp_valid}, 32'h0);
      check("mis_flag_drop", {31'h0, bus.resp_misaligned}, 32'h0);
      check("mis_enable_after", {31'h0, bus.mem_enable}, 32'h0);
      check("mis_ready_back", {31'h0, bus.req_ready}, 32'h1);
      return;
    end

    k    = 1;
    done = 1'b0;
    tmo  = 1'b0;
    while (!done) begin
      check("acc_enable", {31'h0, bus.mem_enable}, 32'h1);
      check("acc_addr", 32'(bus.mem_addr), 32'(addr >> 2));
      check("acc_wr", {28'h0, bus.mem_wr}, exp_wr);
      check("acc_dout", bus.mem_data_out, exp_dout);
      check("acc_req_ready", {31'h0, bus.req_ready}, 32'h0);
      check("acc_no_resp", {31'h0, bus.resp_valid}, 32'h0);
      bus.mem_ready   = (k == delay);
      bus.mem_data_in = (k == delay) ? rd_word : $urandom;
      @(posedge clk);
      @(negedge clk);
      if (k == delay) done = 1'b1;
      else if (k == TIMEOUT) begin
        done = 1'b1;
        tmo  = 1'b1;
      end else if (k > 4 * TIMEOUT) begin
        check("acc_cycle_budget", 32'(k), 32'(TIMEOUT));
        done = 1'b1;
      end
      k++;
    end

    bus.mem_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("resp_valid", {31'h0, bus.resp_valid}, 32'h1);
    check("resp_tmo", {31'h0, bus.resp_timeout}, {31'h0, tmo});
    check("resp_mis", {31'h0, bus.resp_misaligned}, 32'h0);
    check("resp_data", bus.resp_data, (tmo || wr) ? 32'h0 : exp_rd);
    check("resp_enable_low", {31'h0, bus.mem_enable}, 32'h0);
    check("resp_wr_low", {28'h0, bus.mem_wr}, 32'h0);
    @(negedge clk);
    check("post_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("post_data", bus.resp_data, 32'h0);
    check("post_tmo", {31'h0, bus.resp_timeout}, 32'h0);
    check("post_ready", {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    logic [1:0] sz;
    int         dly;
    n_cmp = 0;
    n_bad = 0;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_data     = '0;
    bus.mem_data_in  = '0;
    bus.mem_ready    = 1'b0;
    #12;
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_enable", {31'h0, bus.mem_enable}, 32'h0);
    check("rst_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_dout", bus.mem_data_out, 32'h0);
    check("rst_wr", {28'h0, bus.mem_wr}, 32'h0);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_data", bus.resp_data, 32'h0);
    check("rst_flags", {30'h0, bus.resp_misaligned, bus.resp_timeout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Stores with lane steering
    run_txn(10'h000, 1'b1, 2'd0, 1'b0, 32'h000000AB, 1, 32'h0);
    run_txn(10'h006, 1'b1, 2'd1, 1'b0, 32'h00001234, 1, 32'h0);
    run_txn(10'h008, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 2, 32'h0);
    // Loads with extension
    run_txn(10'h003, 1'b0, 2'd0, 1'b0, 32'h0, 1, 32'h80FF7F01);
    run_txn(10'h003, 1'b0, 2'd0, 1'b1, 32'h0, 3, 32'h80FF7F01);
    run_txn(10'h002, 1'b0, 2'd1, 1'b0, 32'h0, 1, 32'h80FF7F01);
    run_txn(10'h000, 1'b0, 2'd2, 1'b0, 32'h0, 2, 32'h80FF7F01);
    // Misaligned
    run_txn(10'h002, 1'b0, 2'd2, 1'b0, 32'h0, 1, 32'h0);
    run_txn(10'h001, 1'b0, 2'd1, 1'b0, 32'h0, 1, 32'h0);
    run_txn(10'h000, 1'b1, 2'd3, 1'b0, 32'h5, 1, 32'h0);
    // Timeout, then stray ready ignored, then a normal access
    run_txn(10'h010, 1'b0, 2'd2, 1'b0, 32'h0, NEVER, 32'h0);
    bus.mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_ready_resp", {31'h0, bus.resp_valid}, 32'h0);
      check("stray_ready_enable", {31'h0, bus.mem_enable}, 32'h0);
      check("stray_ready_idle", {31'h0, bus.req_ready}, 32'h1);
    end
    bus.mem_ready = 1'b0;
    run_txn(10'h011, 1'b1, 2'd0, 1'b0, 32'h0000005A, 1, 32'h0);
    // Ready on the same edge the counter would expire counts as success
    run_txn(10'h014, 1'b0, 2'd1, 1'b1, 32'h0, TIMEOUT, 32'hC3A5_9F10);

    // Reset in the middle of an access
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h004;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_enable", {31'h0, bus.mem_enable}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_enable", {31'h0, bus.mem_enable}, 32'h0);
    check("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("mid_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    bus.mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("in_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    end
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("after_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    run_txn(10'h005, 1'b0, 2'd0, 1'b0, 32'h0, 2, 32'h1234_F678);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      dly = ($urandom_range(0, 19) == 0) ? NEVER :
            ($urandom_range(0, 9) == 0)  ? TIMEOUT : $urandom_range(1, 4);
      run_txn((AW + 2)'($urandom), 1'($urandom), sz, 1'($urandom), $urandom, dly, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
